// File: rtl/reg_dump_ctrl.sv
// reg_dump_ctrl: streams a contiguous (wrapping) range of register-file
// entries out over a valid/ready interface, one word per two cycles at best.
//
// Ports:
//   clk, rst          - clock; asynchronous active-low reset
//   start, abort      - begin a dump (IDLE only) / cancel a dump in progress
//   first_addr        - first register index, latched with start
//   last_addr         - final register index, latched with start
//   rf_raddr          - register-file read address (registered)
//   rf_rdata          - register-file read data, combinational from rf_raddr
//   out_valid/ready   - output stream handshake
//   out_data/addr     - captured register value and its index
//   out_last          - marks the final word of the dump
//   busy              - high whenever a dump is in progress
//   done              - one-cycle pulse on normal completion
module reg_dump_ctrl #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  abort,
  input  logic [ADDR_WIDTH-1:0] first_addr,
  input  logic [ADDR_WIDTH-1:0] last_addr,
  output logic [ADDR_WIDTH-1:0] rf_raddr,
  input  logic [DATA_WIDTH-1:0] rf_rdata,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic [ADDR_WIDTH-1:0] out_addr,
  output logic                  out_last,
  output logic                  busy,
  output logic                  done
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    READ = 2'd1,
    SEND = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t                state, state_d;
  logic [ADDR_WIDTH-1:0] cur, cur_d;
  logic [ADDR_WIDTH-1:0] stop, stop_d;
  logic [ADDR_WIDTH-1:0] raddr_d;
  logic [DATA_WIDTH-1:0] data_d;
  logic [ADDR_WIDTH-1:0] oaddr_d;
  logic                  valid_d, last_d, busy_d, done_d;

  logic handshake_c;
  logic abort_c;
  logic launch_c;

  assign handshake_c = out_valid && out_ready;
  // Abort only matters once a dump is running.
  assign abort_c     = abort && (state != IDLE);
  // A same-cycle abort suppresses start in IDLE.
  assign launch_c    = start && !abort;

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      cur       <= '0;
      stop      <= '0;
      rf_raddr  <= '0;
      out_data  <= '0;
      out_addr  <= '0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      state     <= state_d;
      cur       <= cur_d;
      stop      <= stop_d;
      rf_raddr  <= raddr_d;
      out_data  <= data_d;
      out_addr  <= oaddr_d;
      out_valid <= valid_d;
      out_last  <= last_d;
      busy      <= busy_d;
      done      <= done_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state;
    case (state)
      IDLE: if (launch_c) state_d = READ;
      READ: state_d = SEND;
      SEND: if (handshake_c) state_d = out_last ? DONE : READ;
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (abort_c) state_d = IDLE;
  end

  // Next values of the registered datapath and outputs.
  always_comb begin
    cur_d   = cur;
    stop_d  = stop;
    raddr_d = rf_raddr;
    data_d  = out_data;
    oaddr_d = out_addr;
    valid_d = out_valid;
    last_d  = out_last;

    case (state)
      IDLE: begin
        if (launch_c) begin
          cur_d   = first_addr;
          stop_d  = last_addr;
          raddr_d = first_addr;
        end
      end
      READ: begin
        // rf_raddr already equals cur, so rf_rdata is the word for cur.
        data_d  = rf_rdata;
        oaddr_d = cur;
        last_d  = (cur == stop);
        valid_d = 1'b1;
      end
      SEND: begin
        if (handshake_c) begin
          valid_d = 1'b0;
          if (out_last) begin
            last_d = 1'b0;
          end else begin
            // Index arithmetic wraps naturally at 2^ADDR_WIDTH.
            cur_d   = ADDR_WIDTH'(cur + 1'b1);
            raddr_d = ADDR_WIDTH'(cur + 1'b1);
          end
        end
      end
      default: ;
    endcase

    if (abort_c) begin
      valid_d = 1'b0;
      last_d  = 1'b0;
      raddr_d = '0;
    end

    busy_d = (state_d != IDLE);
    done_d = (state_d == DONE);
  end

endmodule

// File: tb/tb_reg_dump_ctrl.sv
// Testbench for reg_dump_ctrl: directed scenarios plus randomized dumps,
// checked by a scoreboard fed from a range-level reference model.
module tb_reg_dump_ctrl;

  localparam int unsigned DW = 32;
  localparam int unsigned AW = 5;
  localparam int unsigned NREG = 32;

  logic          clk;
  logic          rst;
  logic          start;
  logic          abort;
  logic [AW-1:0] first_addr;
  logic [AW-1:0] last_addr;
  logic [AW-1:0] rf_raddr;
  logic [DW-1:0] rf_rdata;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_data;
  logic [AW-1:0] out_addr;
  logic          out_last;
  logic          busy;
  logic          done;

  logic [DW-1:0] regs [NREG];
  assign rf_rdata = regs[rf_raddr];

  reg_dump_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .abort      (abort),
    .first_addr (first_addr),
    .last_addr  (last_addr),
    .rf_raddr   (rf_raddr),
    .rf_rdata   (rf_rdata),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_addr   (out_addr),
    .out_last   (out_last),
    .busy       (busy),
    .done       (done)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct packed {
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    logic          l;
  } exp_t;

  exp_t exp_q [$];
  int   checks   = 0;
  int   failures = 0;
  int   done_cnt = 0;
  bit   rnd_ready = 0;
  int   stall_cnt = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
    end
  endtask

  // Advance one clock; inputs change 1ns after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
    if (stall_cnt > 0) begin
      out_ready = 1'b0;
      stall_cnt--;
    end else begin
      out_ready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  endtask

  // Reference: a dump of [f..l] modulo 32 yields every index in that ring order.
  task automatic push_dump(input int f, input int l);
    int n;
    n = ((l - f + 32) % 32) + 1;
    for (int i = 0; i < n; i++) begin
      int a;
      exp_t e;
      a = (f + i) % 32;
      e.a = AW'(a);
      e.d = regs[a];
      e.l = (i == n - 1);
      exp_q.push_back(e);
    end
  endtask

  // Monitor: pops the scoreboard on each accepted word and checks stall stability.
  initial begin : monitor
    bit            have_hold;
    logic [DW-1:0] hold_data;
    logic [AW-1:0] hold_addr;
    logic          hold_last;
    have_hold = 0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        have_hold = 0;
      end else begin
        if (have_hold) begin
          chk("stall_valid", 64'(out_valid), 64'(1));
          chk("stall_data",  64'(out_data),  64'(hold_data));
          chk("stall_addr",  64'(out_addr),  64'(hold_addr));
          chk("stall_last",  64'(out_last),  64'(hold_last));
        end
        have_hold = out_valid && !out_ready && !abort;
        hold_data = out_data;
        hold_addr = out_addr;
        hold_last = out_last;
        if (out_valid && out_ready && !abort) begin
          if (exp_q.size() == 0) begin
            chk("unexpected_word", 64'(1), 64'(0));
          end else begin
            exp_t e;
            e = exp_q.pop_front();
            chk("word_addr", 64'(out_addr), 64'(e.a));
            chk("word_data", 64'(out_data), 64'(e.d));
            chk("word_last", 64'(out_last), 64'(e.l));
          end
        end
        if (done) done_cnt++;
      end
    end
  end

  // One dump: optional stall on stall_addr, optional abort when abort_addr is shown.
  task automatic run_dump(input int f, input int l, input bit rnd,
                          input int stall_addr, input int abort_addr, input int exp_cycles);
    int cyc;
    int d0;
    bit fin;
    bit aborted;
    bit stalled;
    cyc = 0; fin = 0; aborted = 0; stalled = 0;
    rnd_ready = rnd;
    push_dump(f, l);
    d0 = done_cnt;
    first_addr = AW'(f);
    last_addr  = AW'(l);
    start = 1'b1;
    tick();
    start = 1'b0;
    first_addr = AW'($urandom);
    last_addr  = AW'($urandom);
    chk("busy_after_start", 64'(busy), 64'(1));
    while (!fin && cyc < 2000) begin
      tick();
      cyc++;
      if (cyc == 1) chk("first_word_latency", 64'(out_valid), 64'(1));
      if (cyc == 3) start = 1'b0;
      if (done) begin
        fin = 1;
        if (exp_cycles > 0) chk("done_latency", 64'(cyc), 64'(exp_cycles));
      end else if (abort_addr >= 0 && out_valid && int'(out_addr) == abort_addr) begin
        start = 1'b0;
        abort = 1'b1;
        tick();
        abort = 1'b0;
        exp_q.delete();
        chk("abort_busy",  64'(busy),      64'(0));
        chk("abort_valid", 64'(out_valid), 64'(0));
        chk("abort_last",  64'(out_last),  64'(0));
        chk("abort_done",  64'(done),      64'(0));
        chk("abort_raddr", 64'(rf_raddr),  64'(0));
        fin = 1;
        aborted = 1;
      end else if (stall_addr >= 0 && !stalled && out_valid && int'(out_addr) == stall_addr) begin
        stalled = 1;
        out_ready = 1'b0;
        stall_cnt = 4;
      end else if (cyc == 2) begin
        // Re-pulse start with a different range while busy; it must be ignored.
        start = 1'b1;
        first_addr = AW'($urandom);
        last_addr  = AW'($urandom);
      end
    end
    start = 1'b0;
    if (!fin) chk("dump_timeout", 64'(0), 64'(1));
    tick();
    tick();
    if (aborted) begin
      chk("no_done_after_abort", 64'(done_cnt), 64'(d0));
    end else begin
      chk("done_single_pulse", 64'(done_cnt), 64'(d0 + 1));
      chk("idle_after_done",   64'(busy),     64'(0));
    end
    chk("scoreboard_drained", 64'(exp_q.size()), 64'(0));
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_raddr"}, 64'(rf_raddr),  64'(0));
    chk({tag, "_data"},  64'(out_data),  64'(0));
    chk({tag, "_addr"},  64'(out_addr),  64'(0));
    chk({tag, "_valid"}, 64'(out_valid), 64'(0));
    chk({tag, "_last"},  64'(out_last),  64'(0));
    chk({tag, "_busy"},  64'(busy),      64'(0));
    chk({tag, "_done"},  64'(done),      64'(0));
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin : driver
    int d0;
    rst = 1'b0;
    start = 1'b0;
    abort = 1'b0;
    out_ready = 1'b1;
    first_addr = '0;
    last_addr = '0;
    for (int i = 0; i < int'(NREG); i++) regs[i] = $urandom;
    #3;
    chk_all_zero("reset");
    tick();
    tick();
    rst = 1'b1;
    tick();

    // Abort in IDLE, alone and with start, does nothing.
    abort = 1'b1;
    start = 1'b1;
    tick();
    abort = 1'b0;
    start = 1'b0;
    chk("idle_abort_busy", 64'(busy), 64'(0));

    regs[3] = 32'h11; regs[4] = 32'h22; regs[5] = 32'h33;
    run_dump(3, 5, 0, -1, -1, 6);

    regs[7] = 32'hDEADBEEF;
    run_dump(7, 7, 0, -1, -1, 2);

    regs[0] = 32'h0;
    run_dump(30, 1, 0, -1, -1, 8);

    run_dump(3, 6, 0, 4, -1, 13);

    run_dump(10, 15, 0, -1, 11, -1);
    run_dump(0, 0, 0, -1, -1, 2);

    // Asynchronous reset in the middle of a dump.
    d0 = done_cnt;
    rnd_ready = 0;
    push_dump(20, 25);
    first_addr = AW'(20);
    last_addr  = AW'(25);
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    first_addr = AW'(2);
    last_addr  = AW'(3);
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    #2;
    rst = 1'b0;
    #1;
    chk_all_zero("midreset");
    exp_q.delete();
    tick();
    rst = 1'b1;
    tick();
    chk("midreset_no_done", 64'(done_cnt), 64'(d0));
    run_dump(9, 12, 0, -1, -1, 8);

    // Randomized dumps with random backpressure and occasional abort.
    for (int k = 0; k < 20; k++) begin
      int f, l, n, ab;
      for (int i = 0; i < int'(NREG); i++) regs[i] = $urandom;
      f = $urandom_range(0, 31);
      l = $urandom_range(0, 31);
      n = ((l - f + 32) % 32) + 1;
      ab = ($urandom_range(0, 3) == 0) ? (f + $urandom_range(0, n - 1)) % 32 : -1;
      run_dump(f, l, 1, -1, ab, -1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
